// File: rtl/adder_bist_ctrl.sv
// adder_bist_ctrl: BIST controller for the registered prefix-adder wrappers.
// Drives wrapper operands from two Galois LFSRs and checks the wrapper's registered
// {cout,sum} against a golden a+b carried through a LATENCY-deep delay line.
// Optional build macro ADDER_BIST_CORNER_EN: vector indices 0..3 become fixed corner
// operands and the LFSRs hold still while those corners are issued.
module adder_bist_ctrl #(
    parameter int unsigned WIDTH   = 64,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] SEED_A  = 64'hACE1_0000_0000_0001,
    parameter logic [63:0] SEED_B  = 64'h1234_5678_9ABC_DEF1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      num_vec,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [31:0]      first_err_idx
);

    localparam int unsigned IDX_W = 32;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned HEAD  = LATENCY - 1;
    // x^64+x^63+x^61+x^60+1 for WIDTH=64; the same tap shape is kept for other widths
    localparam logic [WIDTH-1:0] TAPS = (WIDTH'(1) << (WIDTH - 1)) | (WIDTH'(1) << (WIDTH - 2))
                                      | (WIDTH'(1) << (WIDTH - 4)) | (WIDTH'(1) << (WIDTH - 5));
    localparam logic [WIDTH-1:0] SEED_A_W = WIDTH'(SEED_A);
    localparam logic [WIDTH-1:0] SEED_B_W = WIDTH'(SEED_B);
`ifdef ADDER_BIST_CORNER_EN
    localparam logic [WIDTH-1:0] PAT_5 = WIDTH'({WIDTH{2'b01}});
    localparam logic [WIDTH-1:0] PAT_A = WIDTH'({WIDTH{2'b10}});
`endif

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic [WIDTH-1:0]   lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
    logic [IDX_W-1:0]   num_vec_q, num_vec_d, vec_idx_q, vec_idx_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [IDX_W-1:0]   first_q, first_d;
    logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic               pipe_vld_q [LATENCY];
    logic [IDX_W-1:0]   pipe_idx_q [LATENCY];
    logic [WIDTH:0]     pipe_exp_q [LATENCY];

    logic [WIDTH-1:0]   src_a, src_b, gen_a, gen_b, gen_a_nx, gen_b_nx;
    logic               line_left, mismatch;
`ifdef ADDER_BIST_CORNER_EN
    logic [IDX_W-1:0]   gen_idx;
`endif

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) r[WIDTH-1-i] = s[i];
        return r;
    endfunction

    // LFSR source: seeds when a run is being launched, running state inside RUN
    always_comb begin
        src_a = SEED_A_W;
        src_b = SEED_B_W;
        if (state_q == RUN) begin
            src_a = lfsr_a_q;
            src_b = lfsr_b_q;
        end
`ifdef ADDER_BIST_CORNER_EN
        gen_idx = (state_q == RUN) ? vec_idx_q + 32'd1 : '0;
`endif
    end

    // Next operand pair and advanced LFSR values for the vector about to be issued
    always_comb begin
        gen_a    = src_a;
        gen_b    = bit_rev(src_b);
        gen_a_nx = lfsr_step(src_a);
        gen_b_nx = lfsr_step(src_b);
`ifdef ADDER_BIST_CORNER_EN
        if (gen_idx < 32'd4) begin
            gen_a_nx = src_a;
            gen_b_nx = src_b;
            case (gen_idx[1:0])
                2'd0:    begin gen_a = '0;    gen_b = '0;        end
                2'd1:    begin gen_a = '1;    gen_b = WIDTH'(1); end
                2'd2:    begin gen_a = '1;    gen_b = '1;        end
                default: begin gen_a = PAT_5; gen_b = PAT_A;     end
            endcase
        end
`endif
    end

    // Entries still in flight once the head has been consumed this cycle
    always_comb begin
        line_left = 1'b0;
        for (int i = 0; i < int'(LATENCY) - 1; i++) line_left = line_left | pipe_vld_q[i];
    end

    // Next-state, operand issue and result bookkeeping
    always_comb begin
        state_d   = state_q;
        op_a_d    = '0;
        op_b_d    = '0;
        lfsr_a_d  = lfsr_a_q;
        lfsr_b_d  = lfsr_b_q;
        num_vec_d = num_vec_q;
        vec_idx_d = vec_idx_q;
        err_d     = err_q;
        first_d   = first_q;

        mismatch = pipe_vld_q[HEAD] && ({dut_cout, dut_sum} != pipe_exp_q[HEAD]);
        if (mismatch) begin
            if (err_q != '1) err_d = err_q + 16'd1;
            if (err_q == '0) first_d = pipe_idx_q[HEAD];
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_vec_d = num_vec;
                    vec_idx_d = '0;
                    err_d     = '0;
                    first_d   = '1;
                    lfsr_a_d  = SEED_A_W;
                    lfsr_b_d  = SEED_B_W;
                    if (num_vec == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RUN;
                        op_a_d   = gen_a;
                        op_b_d   = gen_b;
                        lfsr_a_d = gen_a_nx;
                        lfsr_b_d = gen_b_nx;
                    end
                end
            end
            RUN: begin
                if (vec_idx_q == num_vec_q - 32'd1) begin
                    state_d = DRAIN;
                end else begin
                    op_a_d    = gen_a;
                    op_b_d    = gen_b;
                    lfsr_a_d  = gen_a_nx;
                    lfsr_b_d  = gen_b_nx;
                    vec_idx_d = vec_idx_q + 32'd1;
                end
            end
            DRAIN: begin
                if (!line_left) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    // State, operand, result and delay-line registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            lfsr_a_q  <= SEED_A_W;
            lfsr_b_q  <= SEED_B_W;
            num_vec_q <= '0;
            vec_idx_q <= '0;
            err_q     <= '0;
            first_q   <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= '0;
                pipe_exp_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            lfsr_a_q  <= lfsr_a_d;
            lfsr_b_q  <= lfsr_b_d;
            num_vec_q <= num_vec_d;
            vec_idx_q <= vec_idx_d;
            err_q     <= err_d;
            first_q   <= first_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            // op registers hold a live vector exactly while in RUN
            pipe_vld_q[0] <= (state_q == RUN);
            pipe_idx_q[0] <= vec_idx_q;
            pipe_exp_q[0] <= {1'b0, op_a_q} + {1'b0, op_b_q};
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
                pipe_exp_q[i] <= pipe_exp_q[i-1];
            end
        end
    end

    assign op_a          = op_a_q;
    assign op_b          = op_b_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Testbench for adder_bist_ctrl: wrapper model with injectable faults, operand scoreboard,
// and end-of-run result checks.
module tb_adder_bist_ctrl;

    localparam int unsigned W   = 64;
    localparam int unsigned LAT = 2;
    localparam logic [63:0] SA   = 64'hACE1_0000_0000_0001;
    localparam logic [63:0] SB   = 64'h1234_5678_9ABC_DEF1;
    localparam logic [63:0] POLY = 64'hD800_0000_0000_0000;
`ifdef ADDER_BIST_CORNER_EN
    localparam bit CORNER = 1'b1;
`else
    localparam bit CORNER = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   num_vec;
    logic [W-1:0]  op_a, op_b, dut_sum;
    logic          dut_cout;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [31:0]   first_err_idx;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            fault_mode = 0;   // 0 ideal, 1 sum[17] stuck-0, 2 cout tied 0, 3 three-cycle delay
    int            busy_cnt = 0;
    int            pop_cnt  = 0;
    logic [127:0]  exp_q [$];
    logic [64:0]   wst [3];
    logic [64:0]   wraw;

    adder_bist_ctrl #(.WIDTH(W), .LATENCY(LAT), .SEED_A(SA), .SEED_B(SB)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vec(num_vec),
        .op_a(op_a), .op_b(op_b), .dut_sum(dut_sum), .dut_cout(dut_cout),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx)
    );

    always #5 clk = ~clk;

    // Registered adder wrapper model
    always @(posedge clk) begin
        wst[0] <= {1'b0, op_a} + {1'b0, op_b};
        wst[1] <= wst[0];
        wst[2] <= wst[1];
    end

    always_comb begin
        wraw     = (fault_mode == 3) ? wst[2] : wst[1];
        dut_sum  = wraw[63:0];
        if (fault_mode == 1) dut_sum[17] = 1'b0;
        dut_cout = (fault_mode == 2) ? 1'b0 : wraw[64];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m_step(input logic [63:0] s);
        logic [63:0] r;
        r = {1'b0, s[63:1]};
        if (s[0]) r = r ^ POLY;
        return r;
    endfunction

    function automatic logic [63:0] m_rev(input logic [63:0] s);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[63-i] = s[i];
        return r;
    endfunction

    // Pushes the expected operand sequence and predicts error results for the fault mode
    task automatic gen_expected(input int n, input int mode, output int e_err, output logic [31:0] e_first);
        logic [63:0] la, lb, a, b;
        logic [64:0] s;
        bit bad;
        la = SA; lb = SB; e_err = 0; e_first = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            if (CORNER && i < 4) begin
                case (i)
                    0: begin a = 64'h0; b = 64'h0; end
                    1: begin a = '1;    b = 64'h1; end
                    2: begin a = '1;    b = '1;    end
                    default: begin a = 64'h5555_5555_5555_5555; b = 64'hAAAA_AAAA_AAAA_AAAA; end
                endcase
            end else begin
                a = la; b = m_rev(lb);
                la = m_step(la); lb = m_step(lb);
            end
            exp_q.push_back({a, b});
            s = {1'b0, a} + {1'b0, b};
            bad = (mode == 1) ? s[17] : (mode == 2) ? s[64] : 1'b0;
            if (bad) begin
                if (e_err == 0) e_first = 32'(i);
                e_err++;
            end
        end
    endtask

    // Operand scoreboard: one popped entry per busy cycle, zeros during drain
    always @(negedge clk) begin
        logic [127:0] v;
        if (rst_n && busy) begin
            busy_cnt++;
            if (exp_q.size() > 0) begin
                v = exp_q.pop_front();
                chk("op_a", op_a, v[127:64]);
                chk("op_b", op_b, v[63:0]);
                pop_cnt++;
            end else begin
                chk("drain_op_a", op_a, 64'h0);
            end
        end
    end

    task automatic chk_reset_vals();
        chk("rst_op_a", op_a, 64'h0);
        chk("rst_op_b", op_b, 64'h0);
        chk("rst_busy", busy, 64'h0);
        chk("rst_done", done, 64'h0);
        chk("rst_pass", pass, 64'h0);
        chk("rst_err", err_count, 64'h0);
        chk("rst_first", first_err_idx, 64'hFFFF_FFFF);
    endtask

    task automatic run(input int n, input int mode, input bit repulse);
        int          e_err;
        logic [31:0] e_first;
        bit          got_done;
        fault_mode = mode;
        exp_q.delete();
        gen_expected(n, mode, e_err, e_first);
        busy_cnt = 0; pop_cnt = 0;
        @(negedge clk); start = 1'b1; num_vec = 32'(n);
        @(negedge clk); start = 1'b0; num_vec = 32'd7;
        got_done = 1'b0;
        for (int c = 0; c < n + 50; c++) begin
            start = (repulse && c == n / 3) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (done) begin got_done = 1'b1; break; end
        end
        start = 1'b0;
        chk("done_seen", got_done, 1);
        chk("busy_cycles", 64'(busy_cnt), 64'(n + LAT));
        chk("vec_issued", 64'(pop_cnt), 64'(n));
        chk("queue_empty", 64'(exp_q.size()), 0);
        if (mode == 3) begin
            chk("dly_err_nz", err_count != 16'h0, 1);
            chk("dly_pass", pass, 0);
        end else begin
            chk("err_count", err_count, 64'(e_err));
            chk("first_err", first_err_idx, e_first);
            chk("pass", pass, (e_err == 0));
            repeat (3) @(negedge clk);
            chk("done_hold", done, 1);
            chk("err_hold", err_count, 64'(e_err));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          e_err;
        logic [31:0] e_first;
        rst_n = 1'b0; start = 1'b0; num_vec = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(1000, 0, 1'b0);
        run(1000, 1, 1'b0);

        // zero-length run straight to DONE
        @(negedge clk); start = 1'b1; num_vec = 32'd0;
        @(negedge clk); start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_pass", pass, 1);
        chk("zero_busy", busy, 0);
        chk("zero_err", err_count, 0);
        chk("zero_first", first_err_idx, 64'hFFFF_FFFF);
        repeat (3) begin
            @(negedge clk);
            chk("zero_busy_hold", busy, 0);
            chk("zero_op_a", op_a, 0);
        end

        run(2, 2, 1'b0);

        // reset in the middle of a run
        fault_mode = 0;
        exp_q.delete();
        gen_expected(1000, 0, e_err, e_first);
        busy_cnt = 0; pop_cnt = 0;
        @(negedge clk); start = 1'b1; num_vec = 32'd1000;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 600 && pop_cnt < 500; c++) @(negedge clk);
        chk("mid_run_reached", 64'(pop_cnt >= 500), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("post_rst_idle", busy, 0);

        run(1000, 0, 1'b0);
        run(300, 0, 1'b1);
        run(50, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
